// File: rtl/ed25519_pkg.sv
// +----------------------------------------------------------------------------+
// | ed25519_pkg: field constants and inverter encodings for the ed25519 path.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package ed25519_pkg;

  localparam int FIELD_W = 256;

  localparam logic [FIELD_W-1:0] P_MOD = (256'd1 << 255) - 256'd19;
  localparam logic [FIELD_W-1:0] EXP   = P_MOD - 256'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SQ_REQ   = 3'd1,
    ST_SQ_WAIT  = 3'd2,
    ST_MUL_REQ  = 3'd3,
    ST_MUL_WAIT = 3'd4,
    ST_FINISH   = 3'd5
  } inv_state_t;

  typedef enum logic [1:0] {
    OP_SQ  = 2'd0,
    OP_MUL = 2'd1,
    OP_FIN = 2'd2
  } inv_op_t;

endpackage

`default_nettype wire

// File: rtl/inv_exp_sequencer.sv
// +----------------------------------------------------------------------------+
// | inv_exp_sequencer: exponent bit index and next-operation decision.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module inv_exp_sequencer
  import ed25519_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic       after_mul,
  output inv_op_t    next_op,
  output logic [7:0] idx
);

  // Bit 254 is absorbed by seeding the accumulator with x.
  localparam logic [7:0] c_first_bit = 8'd253;

  logic [7:0] r_idx;
  logic       w_exp_bit;

  assign w_exp_bit = EXP[r_idx];
  assign idx       = r_idx;

  always_comb begin
    next_op = OP_SQ;
    if (!after_mul && w_exp_bit) begin
      next_op = OP_MUL;
    end else if (r_idx == 8'd0) begin
      next_op = OP_FIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 8'd0;
    end else if (load) begin
      r_idx <= c_first_bit;
    end else if (step && next_op == OP_SQ) begin
      r_idx <= r_idx - 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_inv_25519.sv
// +----------------------------------------------------------------------------+
// | seq_inv_25519: Fermat inverter x^(p-2) mod p driving an external multiplier.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_inv_25519
  import ed25519_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FIELD_W-1:0] x,
  output logic [FIELD_W-1:0] inv,
  output logic               done,
  output logic               busy,
  output logic               mul_start,
  output logic [FIELD_W-1:0] mul_a,
  output logic [FIELD_W-1:0] mul_b,
  input  logic [FIELD_W-1:0] mul_product,
  input  logic               mul_done
);

  inv_state_t         r_state;
  logic [FIELD_W-1:0] r_xr;
  logic [FIELD_W-1:0] r_inv;
  logic [FIELD_W-1:0] r_mul_a;
  logic [FIELD_W-1:0] r_mul_b;
  logic               r_done;
  logic               r_busy;
  logic               r_mul_start;

  logic               w_load;
  logic               w_in_wait;
  logic               w_step;
  logic               w_after_mul;
  inv_op_t            w_next_op;
  logic [7:0]         w_idx;

  assign w_load      = (r_state == ST_IDLE) && start;
  assign w_in_wait   = (r_state == ST_SQ_WAIT) || (r_state == ST_MUL_WAIT);
  assign w_step      = w_in_wait && mul_done;
  assign w_after_mul = (r_state == ST_MUL_WAIT);

  inv_exp_sequencer u_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .step      (w_step),
    .after_mul (w_after_mul),
    .next_op   (w_next_op),
    .idx       (w_idx)
  );

  // mul_a doubles as the accumulator; operands are loaded on the edge that
  // enters a *_REQ state so the request goes out one cycle after mul_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_xr        <= '0;
      r_inv       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_mul_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_xr        <= x;
            r_mul_a     <= x;
            r_mul_b     <= x;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_SQ_REQ;
          end
        end
        ST_SQ_REQ:  r_state <= ST_SQ_WAIT;
        ST_MUL_REQ: r_state <= ST_MUL_WAIT;
        ST_SQ_WAIT, ST_MUL_WAIT: begin
          if (mul_done) begin
            case (w_next_op)
              OP_MUL: begin
                r_mul_a     <= mul_product;
                r_mul_b     <= r_xr;
                r_mul_start <= 1'b1;
                r_state     <= ST_MUL_REQ;
              end
              OP_SQ: begin
                r_mul_a     <= mul_product;
                r_mul_b     <= mul_product;
                r_mul_start <= 1'b1;
                r_state     <= ST_SQ_REQ;
              end
              default: begin
                // Completion lands back in IDLE so a start in the done cycle is taken.
                r_inv   <= mul_product;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign inv       = r_inv;
  assign done      = r_done;
  assign busy      = r_busy;
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

endmodule

`default_nettype wire

// File: tb/tb_seq_inv_25519.sv
// +----------------------------------------------------------------------------+
// | tb_seq_inv_25519: directed bench with a modular multiplier model.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_inv_25519;
  import ed25519_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] x = '0;
  logic [255:0] inv;
  logic         done;
  logic         busy;
  logic         mul_start;
  logic [255:0] mul_a;
  logic [255:0] mul_b;
  logic [255:0] mul_product = '0;
  logic         mul_done = 1'b0;

  int           lat = 2;
  int           cnt = 0;
  logic         prev_ms = 1'b0;
  logic [255:0] pa = '0;
  logic [255:0] pb = '0;
  int           npulse = 0;
  int           viol = 0;

  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  seq_inv_25519 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x           (x),
    .inv         (inv),
    .done        (done),
    .busy        (busy),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_done    (mul_done)
  );

  function automatic logic [255:0] modmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] pr;
    pr = {256'd0, a} * {256'd0, b};
    pr = pr % {256'd0, P_MOD};
    return pr[255:0];
  endfunction

  // Multiplier model: mul_done appears lat cycles after mul_start; it keeps
  // running through a DUT reset so a stale completion reaches the DUT.
  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mul_done    <= 1'b1;
        mul_product <= modmul(pa, pb);
      end
    end
    if (mul_start) begin
      if (prev_ms || cnt != 0) viol <= viol + 1;
      pa     <= mul_a;
      pb     <= mul_b;
      cnt    <= lat - 1;
      npulse <= npulse + 1;
    end
    prev_ms <= mul_start;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_inv(input logic [255:0] xv, input int l, input bit spam,
                         output logic [255:0] res, output int cyc,
                         output int pulses, output logic busy_at_done);
    int base;
    int bound;
    bit seen;
    lat   = l;
    base  = npulse;
    bound = 506 * (l + 1) + 50;
    seen  = 1'b0;
    @(negedge clk);
    x     = xv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < bound) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (spam && cyc >= 5 && cyc < 40) begin
        start = cyc[0];
        x     = ~xv;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start        = 1'b0;
    res          = inv;
    busy_at_done = busy;
    pulses       = npulse - base;
    check_eq("done_seen", {255'd0, seen}, 256'd1);
    @(negedge clk);
    check_eq("done_one_cycle", {255'd0, done}, 256'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_done"},  {255'd0, done}, 256'd0);
    check_eq({tag, "_busy"},  {255'd0, busy}, 256'd0);
    check_eq({tag, "_mstart"}, {255'd0, mul_start}, 256'd0);
    check_eq({tag, "_mul_a"}, mul_a, 256'd0);
    check_eq({tag, "_mul_b"}, mul_b, 256'd0);
    check_eq({tag, "_inv"},   inv, 256'd0);
  endtask

  initial begin
    logic [255:0] res;
    logic [255:0] half;
    logic [255:0] third;
    logic [255:0] xr;
    logic [256:0] t;
    logic         bad;
    int           cyc;
    int           pulses;
    int           stray;
    int           base;
    int           wait_cyc;

    half  = (256'd1 << 254) - 256'd9;
    t     = ({1'b0, P_MOD} << 1) + 257'd1;
    t     = t / 257'd3;
    third = t[255:0];

    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;

    run_inv(256'd1, 2, 1'b0, res, cyc, pulses, bad);
    check_eq("x1_inv", res, 256'd1);
    check_eq("x1_done_cycle", 256'(cyc), 256'd1519);
    check_eq("x1_pulses", 256'(pulses), 256'd506);
    check_eq("x1_busy_at_done", {255'd0, bad}, 256'd1);

    run_inv(256'd2, 3, 1'b0, res, cyc, pulses, bad);
    check_eq("x2_inv", res, half);
    check_eq("x2_product", modmul(256'd2, res), 256'd1);

    run_inv(256'd0, 7, 1'b0, res, cyc, pulses, bad);
    check_eq("x0_inv", res, 256'd0);
    check_eq("x0_done_cycle", 256'(cyc), 256'(506 * 8 + 1));

    run_inv(P_MOD + 256'd2, 2, 1'b0, res, cyc, pulses, bad);
    check_eq("xbig_inv", res, half);

    for (int n = 0; n < 6; n++) begin
      xr = '0;
      for (int k = 0; k < 8; k++) xr = {xr[223:0], 32'($urandom())};
      xr = xr % P_MOD;
      if (xr == 256'd0) xr = 256'd1;
      run_inv(xr, int'($urandom_range(2, 5)), 1'b0, res, cyc, pulses, bad);
      check_eq($sformatf("rand%0d_product", n), modmul(xr, res), 256'd1);
    end

    run_inv(256'd2, 2, 1'b1, res, cyc, pulses, bad);
    check_eq("busy_start_inv", res, half);
    check_eq("busy_start_pulses", 256'(pulses), 256'd506);

    // Reset while the multiplier model has a transaction outstanding.
    lat  = 4;
    base = npulse;
    @(negedge clk);
    x     = 256'd5;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_cyc = 0;
    while ((npulse - base) < 100 && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_eq("reach_txn100", 256'(npulse - base), 256'd100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || mul_start || busy) stray++;
    end
    check_eq("late_mul_done_ignored", 256'(stray), 256'd0);

    run_inv(256'd3, 2, 1'b0, res, cyc, pulses, bad);
    check_eq("x3_inv", res, third);
    check_eq("x3_pulses", 256'(pulses), 256'd506);

    check_eq("protocol_violations", 256'(viol), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
